// File: rtl/mem_ctrl_if.sv
// CPU-side memory bus: NUM_RD synchronous read ports plus one write port.
interface mem_ctrl_if #(
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD-1:0]    ren;
  logic [16*NUM_RD-1:0] raddr;
  logic [16*NUM_RD-1:0] rdata;
  logic                 wen;
  logic [15:0]          waddr;
  logic [15:0]          wdata;

  modport master (output ren, raddr, wen, waddr, wdata, input rdata);
  modport slave  (input ren, raddr, wen, waddr, wdata, output rdata);
endinterface

// File: rtl/mem_ctrl.sv
// Banked memory-mapped store (RAM, tile map, frame buffer, IO) with a two-stage
// tile-display pipeline and a hardware frame-buffer clear engine.
module mem_ctrl #(
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned RAM_DEPTH     = 8192,
  parameter logic [15:0] TILEMAP_START = 16'hC000,
  parameter int unsigned TILEMAP_DEPTH = 8192,
  parameter logic [15:0] FB_START      = 16'hE000,
  parameter int unsigned FB_DEPTH      = 4096,
  parameter logic [15:0] IO_START      = 16'hF000,
  parameter int unsigned FB_ROW_SHIFT  = 7
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic              ps2_ren,
  input  logic [15:0]       ps2_data_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              pix_req,
  output logic [11:0]       pixel,
  output logic              pixel_valid,
  output logic              clr_busy
);

  localparam int unsigned RamAw  = $clog2(RAM_DEPTH);
  localparam int unsigned TileAw = $clog2(TILEMAP_DEPTH);
  localparam int unsigned FbAw   = $clog2(FB_DEPTH);
  localparam int unsigned FaW    = FbAw + 1;

  localparam logic [2:0] SelNone = 3'd0;
  localparam logic [2:0] SelRam  = 3'd1;
  localparam logic [2:0] SelTile = 3'd2;
  localparam logic [2:0] SelFb   = 3'd3;
  localparam logic [2:0] SelIo   = 3'd4;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  // Region select; offsets past a region's depth fall through to SelNone.
  function automatic logic [2:0] decode(input logic [15:0] addr);
    if (addr < TILEMAP_START) begin
      return (32'(addr) < RAM_DEPTH) ? SelRam : SelNone;
    end else if (addr < FB_START) begin
      return (32'(addr - TILEMAP_START) < TILEMAP_DEPTH) ? SelTile : SelNone;
    end else if (addr < IO_START) begin
      return (32'(addr - FB_START) < FB_DEPTH) ? SelFb : SelNone;
    end else begin
      return ((addr - IO_START) < 16'd3) ? SelIo : SelNone;
    end
  endfunction

  logic [15:0] ram_mem  [RAM_DEPTH];
  logic [15:0] tile_mem [TILEMAP_DEPTH];
  logic [15:0] fb_mem   [FB_DEPTH];

  logic [0:0]      state_q, state_d;
  logic [FbAw-1:0] ptr_q, ptr_d;
  logic [15:0]     clr_fill_q, clr_fill_d;
  logic [15:0]     fill_q, fill_d;

  logic [15:0] raddr_a [NUM_RD];
  logic [15:0] rd_word [NUM_RD];
  logic [15:0] rdata_q [NUM_RD];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign raddr_a[g]            = bus.raddr[16*g +: 16];
    assign bus.rdata[16*g +: 16] = rdata_q[g];
  end

  assign clr_busy = (state_q == StClear);

  // Read path.
  always_comb begin
    ps2_ren = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_word[i] = 16'h0000;
      if (bus.ren[i] && raddr_a[i] == IO_START) ps2_ren = 1'b1;
      case (decode(raddr_a[i]))
        SelRam:  rd_word[i] = ram_mem[RamAw'(raddr_a[i])];
        SelTile: rd_word[i] = tile_mem[TileAw'(raddr_a[i] - TILEMAP_START)];
        SelFb:   rd_word[i] = fb_mem[FbAw'(raddr_a[i] - FB_START)];
        SelIo: begin
          case (2'(raddr_a[i] - IO_START))
            2'd0:    rd_word[i] = ps2_data_in;
            2'd1:    rd_word[i] = {15'b0, clr_busy};
            2'd2:    rd_word[i] = fill_q;
            default: rd_word[i] = 16'h0000;
          endcase
        end
        default: rd_word[i] = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) rdata_q[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.ren[i]) rdata_q[i] <= rd_word[i];
      end
    end
  end

  // Write decode.
  logic [2:0] wsel;
  logic       cpu_fb_we, clr_start, fill_we, clr_we;

  always_comb begin
    wsel      = decode(bus.waddr);
    cpu_fb_we = bus.wen && (wsel == SelFb);
    clr_start = bus.wen && (wsel == SelIo) && (2'(bus.waddr - IO_START) == 2'd1);
    fill_we   = bus.wen && (wsel == SelIo) && (2'(bus.waddr - IO_START) == 2'd2);
    // A CPU frame-buffer write or a restart takes the cycle; the engine stalls.
    clr_we    = (state_q == StClear) && !cpu_fb_we && !clr_start;
  end

  always_ff @(posedge clk) begin
    if (bus.wen && wsel == SelRam)  ram_mem[RamAw'(bus.waddr)] <= bus.wdata;
    if (bus.wen && wsel == SelTile) tile_mem[TileAw'(bus.waddr - TILEMAP_START)] <= bus.wdata;
    if (cpu_fb_we)   fb_mem[FbAw'(bus.waddr - FB_START)] <= bus.wdata;
    else if (clr_we) fb_mem[ptr_q] <= clr_fill_q;
  end

  // Clear engine.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_fill_d = clr_fill_q;
    fill_d     = fill_we ? bus.wdata : fill_q;
    if (clr_start) begin
      state_d    = StClear;
      ptr_d      = '0;
      clr_fill_d = fill_q;
    end else if (clr_we) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == FbAw'(FB_DEPTH - 1)) state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      clr_fill_q <= 16'h0000;
      fill_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_fill_q <= clr_fill_d;
      fill_q     <= fill_d;
    end
  end

  // Display pipeline: stage 1 fetches the frame-buffer word, stage 2 the tile texel.
  logic [FaW-1:0] fa;
  logic [15:0]    s1_word_q;
  logic           s1_hi_q, s1_valid_q;
  logic [2:0]     s1_px_q, s1_py_q;
  logic [7:0]     tile;
  logic [15:0]    idx;
  logic [11:0]    pixel_d;

  always_comb begin
    fa      = FaW'(16'(pixel_x >> 3) + (16'(pixel_y >> 3) << FB_ROW_SHIFT));
    tile    = s1_hi_q ? s1_word_q[15:8] : s1_word_q[7:0];
    idx     = {2'b00, tile, 6'b000000} + {10'b0, s1_py_q, 3'b000} + {13'b0, s1_px_q};
    pixel_d = (32'(idx) < TILEMAP_DEPTH) ? tile_mem[TileAw'(idx)][11:0] : 12'h000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_word_q   <= 16'h0000;
      s1_hi_q     <= 1'b0;
      s1_px_q     <= 3'd0;
      s1_py_q     <= 3'd0;
      s1_valid_q  <= 1'b0;
      pixel       <= 12'h000;
      pixel_valid <= 1'b0;
    end else begin
      s1_word_q   <= fb_mem[fa[FbAw:1]];
      s1_hi_q     <= fa[0];
      s1_px_q     <= pixel_x[2:0];
      s1_py_q     <= pixel_y[2:0];
      s1_valid_q  <= pix_req;
      pixel       <= pixel_d;
      pixel_valid <= s1_valid_q;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: decode, PS/2 strobe, display pipeline, clear engine, reset.
module tb_mem_ctrl;

  localparam int unsigned FbDepth = 4096;

  logic        clk, rst;
  logic        ps2_ren;
  logic [15:0] ps2_data_in;
  logic [9:0]  pixel_x, pixel_y;
  logic        pix_req;
  logic [11:0] pixel;
  logic        pixel_valid, clr_busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_ctrl_if #(.NUM_RD(2)) bus ();

  mem_ctrl #(.NUM_RD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ps2_ren     (ps2_ren),
    .ps2_data_in (ps2_data_in),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pix_req     (pix_req),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .clr_busy    (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    bus.wen = 1'b1; bus.waddr = a; bus.wdata = d;
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  task automatic read2(input logic [15:0] a0, input logic [15:0] a1);
    bus.ren = 2'b11; bus.raddr = {a1, a0};
    @(negedge clk);
    bus.ren = 2'b00;
  endtask

  task automatic wait_idle(inout int c);
    while (clr_busy && c < 20000) begin
      @(negedge clk);
      c++;
    end
  endtask

  logic [9:0]  px_v  [5] = '{10'd1, 10'd9, 10'd0, 10'd16, 10'd24};
  logic [9:0]  py_v  [5] = '{10'd1, 10'd1, 10'd0, 10'd0, 10'd0};
  logic [11:0] exp_v [5] = '{12'hF00, 12'h0A5, 12'h123, 12'h000, 12'h000};

  initial begin
    int c;
    int bad;
    rst = 1'b1;
    bus.ren = '0; bus.raddr = '0; bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    ps2_data_in = 16'h0000; pixel_x = '0; pixel_y = '0; pix_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_pixel", {pixel_valid, pixel}, 13'h0);
    check("rst_busy", clr_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Decode across regions.
    cpu_write(16'h0010, 16'h1234);
    cpu_write(16'hC005, 16'hABCD);
    cpu_write(16'hE001, 16'h0302);
    cpu_write(16'h0000, 16'h1111);
    cpu_write(16'h2000, 16'hDEAD);
    read2(16'h0010, 16'hC005);
    check("rd_ram", bus.rdata[15:0], 16'h1234);
    check("rd_tile", bus.rdata[31:16], 16'hABCD);
    read2(16'hE001, 16'hF005);
    check("rd_fb", bus.rdata[15:0], 16'h0302);
    check("rd_io_unmapped", bus.rdata[31:16], 16'h0000);
    read2(16'h0000, 16'h2000);
    check("rd_ram0_no_alias", bus.rdata[15:0], 16'h1111);
    check("rd_ram_out_of_depth", bus.rdata[31:16], 16'h0000);
    @(negedge clk);
    check("rd_hold", bus.rdata, {16'h0000, 16'h1111});

    // Read-during-write returns old data.
    bus.wen = 1'b1; bus.waddr = 16'h0010; bus.wdata = 16'h5555;
    bus.ren = 2'b01; bus.raddr = {16'h0000, 16'h0010};
    @(negedge clk);
    bus.wen = 1'b0; bus.ren = 2'b00;
    check("rdw_old", bus.rdata[15:0], 16'h1234);
    read2(16'h0010, 16'h0010);
    check("rdw_new", bus.rdata, {16'h5555, 16'h5555});

    // PS/2 strobe.
    ps2_data_in = 16'h0041;
    bus.ren = 2'b11; bus.raddr = {16'hF000, 16'hF000};
    #1 check("ps2_ren_hi", ps2_ren, 1'b1);
    @(negedge clk);
    bus.ren = 2'b00;
    #1 check("ps2_ren_lo", ps2_ren, 1'b0);
    check("ps2_data", bus.rdata, {16'h0041, 16'h0041});
    @(negedge clk);

    // Display pipeline.
    cpu_write(16'hE000, 16'h0201);
    cpu_write(16'hE001, 16'h80FF);
    cpu_write(16'hC049, 16'h0F00);
    cpu_write(16'hC089, 16'hF0A5);
    cpu_write(16'hC040, 16'h0123);
    cpu_write(16'hC000, 16'h0777);
    cpu_write(16'hDFC0, 16'h0666);
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        pix_req = 1'b1; pixel_x = px_v[k]; pixel_y = py_v[k];
      end else begin
        pix_req = 1'b0;
      end
      @(negedge clk);
      if (k >= 1 && k <= 5) begin
        check($sformatf("pix%0d", k - 1), {pixel_valid, pixel}, {1'b1, exp_v[k-1]});
      end else begin
        check($sformatf("pix_valid_lo%0d", k), pixel_valid, 1'b0);
      end
    end

    // Uncontended clear.
    cpu_write(16'hF002, 16'h0505);
    cpu_write(16'hF001, 16'h0000);
    c = 0;
    read2(16'hF001, 16'hF002);
    c++;
    check("clr_ctrl_rd", bus.rdata, {16'h0505, 16'h0001});
    wait_idle(c);
    check("clr_cycles", c, FbDepth);
    bad = 0;
    for (int i = 0; i < FbDepth; i += 2) begin
      read2(16'(32'hE000 + i), 16'(32'hE000 + i + 1));
      if (bus.rdata !== {16'h0505, 16'h0505}) bad++;
    end
    check("clr_words_bad", bad, 0);

    // Contended clear, fill register changed mid-clear.
    cpu_write(16'hF002, 16'h0A0A);
    cpu_write(16'hF001, 16'h0000);
    c = 0;
    repeat (20) @(negedge clk);
    c += 20;
    cpu_write(16'hE010, 16'h7777);
    c++;
    cpu_write(16'hF002, 16'h1111);
    c++;
    wait_idle(c);
    check("clr_stall_cycles", c, FbDepth + 1);
    read2(16'hE010, 16'hE00F);
    check("clr_cpu_wins", bus.rdata, {16'h0A0A, 16'h7777});
    read2(16'hE011, 16'hEFFF);
    check("clr_fill_latched", bus.rdata, {16'h0A0A, 16'h0A0A});
    read2(16'hF002, 16'hF001);
    check("fill_reg_idle", bus.rdata, {16'h0000, 16'h1111});

    // Restart mid-clear.
    cpu_write(16'hF001, 16'h0000);
    repeat (100) @(negedge clk);
    cpu_write(16'hF002, 16'h2222);
    cpu_write(16'hF001, 16'h0000);
    c = 0;
    wait_idle(c);
    check("restart_cycles", c, FbDepth);
    read2(16'hE000, 16'hE032);
    check("restart_lo", bus.rdata, {16'h2222, 16'h2222});
    read2(16'hEFFF, 16'hEFFF);
    check("restart_last", bus.rdata[15:0], 16'h2222);

    // Asynchronous reset mid-clear with traffic.
    cpu_write(16'hC880, 16'h0ABC);
    cpu_write(16'hF002, 16'h3333);
    cpu_write(16'hF001, 16'h0000);
    bus.ren = 2'b01; bus.raddr = {16'h0000, 16'h0010};
    pix_req = 1'b1; pixel_x = 10'd640; pixel_y = 10'd120;
    repeat (10) @(negedge clk);
    check("pre_rst_state", {clr_busy, pixel_valid, pixel, bus.rdata[15:0]},
          {1'b1, 1'b1, 12'hABC, 16'h5555});
    #2 rst = 1'b1;
    #1 check("async_rst_rdata", bus.rdata, 32'h0);
    check("async_rst_pixel", {pixel_valid, pixel}, 13'h0);
    check("async_rst_busy", clr_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0; bus.ren = 2'b00; pix_req = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", clr_busy, 1'b0);
    read2(16'hE000, 16'hEFFF);
    check("partial_clear", bus.rdata, {16'h2222, 16'h3333});
    read2(16'hF002, 16'hE064);
    check("post_rst_fill", bus.rdata, {16'h2222, 16'h0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
